fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the CPU core.
- Owns the program counter, reads 16-bit instructions from synchronous instruction memory, and presents each one on the core's instruction input with a one-cycle load strobe.
- Pulses the core's start input, waits for the core's wait/idle flag to return high, then advances or redirects the PC.
- Detects a HALT opcode and stops fetching.

Parameters:
PC_WIDTH, 8, program counter and memory address width
INSTR_WIDTH, 16, instruction width
RESET_PC, 0, PC value after reset
MEM_LATENCY, 1, cycles from the mem_rd cycle to valid mem_rdata (legal 1..3)
HALT_OPCODE, 3'b111, value of instr[15:13] that halts fetch

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
run  in  1  level enable for continuous fetch
mem_addr  out  PC_WIDTH  instruction memory address
mem_rd  out  1  memory read strobe, one cycle per fetch
mem_rdata  in  INSTR_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_rd
ir_out  out  INSTR_WIDTH  registered instruction, drives core `in`
ir_load  out  1  one-cycle strobe, drives core `load`
cpu_s  out  1  one-cycle start pulse, drives core `s`
cpu_w  in  1  core idle flag (1 = core waiting for start)
pc_redirect  in  1  take pc_target instead of PC+1; sampled only at instruction completion
pc_target  in  PC_WIDTH  redirect target
pc  out  PC_WIDTH  current PC
halted  out  1  sticky halt indication

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC, ir_out=0.
  - mem_rd, ir_load, cpu_s and halted all 0. mem_addr follows pc.
- States:
  - IDLE: go to FETCH when run=1 and cpu_w=1; otherwise hold.
  - FETCH: mem_rd=1 and mem_addr=pc for exactly one cycle. Go to MEMWAIT if MEM_LATENCY>1, else CAPTURE.
  - MEMWAIT: count MEM_LATENCY-1 cycles, then go to CAPTURE.
  - CAPTURE: ir_out <= mem_rdata. If mem_rdata[15:13]==HALT_OPCODE go to HALT, else go to LOAD.
  - LOAD: ir_load=1 for one cycle. Go to START.
  - START: cpu_s=1 for one cycle. Go to BUSY.
  - BUSY: wait for cpu_w=0 (core has left idle), then go to DONE. If cpu_w is still 1 after 2 cycles, go to DONE anyway; this covers single-cycle core ops.
  - DONE: wait for cpu_w=1. On that cycle:
    - pc <= pc_redirect ? pc_target : pc+1.
    - Next state is FETCH if run=1, else IDLE.
  - HALT: halted=1. pc holds the HALT instruction's address. No strobes. Exit only by reset.
- Latency, MEM_LATENCY=1, starting from run rising in IDLE: FETCH at c0, CAPTURE c1, ir_load c2, cpu_s c3.
- PC arithmetic: modulo 2^PC_WIDTH; 8'hFF+1 wraps to 8'h00.
- run deasserted mid-instruction: the current instruction completes through DONE (PC updated), then the unit goes to IDLE.
- pc_redirect asserted in any cycle other than the DONE completion cycle: ignored.
- ir_out holds its value between fetches. A HALT instruction is captured into ir_out but never loaded (no ir_load, no cpu_s).
- At most one of mem_rd, ir_load, cpu_s is high in any cycle.

Optional Feature:
- Macro: FETCH_STEP_EN.
- Defined:
  - Adds input port `step` (1 bit).
  - IDLE goes to FETCH only on a cycle where step=1 and cpu_w=1; run is ignored for this transition.
  - DONE always returns to IDLE.
  - Result: exactly one instruction per step pulse.
- Undefined: no `step` port; run-level continuous fetch as described above.

Decomposition:
- Package risc_fetch_pkg:
  - fetch_state_t enum: IDLE, FETCH, MEMWAIT, CAPTURE, LOAD, START, BUSY, DONE, HALT.
  - HALT_OPCODE default.
  - Opcode field position constants (15:13).
- Sub-module pc_reg: holds the PC; takes async active-low reset, advance, redirect and target; outputs pc.
- The FSM and the MEMWAIT counter stay in fetch_unit.

Test Plan:
- Reset mid-BUSY with pc=8'h05 → pc=8'h00, halted=0, all strobes 0 immediately; a fresh fetch from address 0 follows run=1.
- MEM_LATENCY=1, mem[0]=16'hD105, run=1, core model drops cpu_w for 4 cycles → mem_rd at c0, ir_out=16'hD105 with ir_load at c2, cpu_s at c3, pc=1 after cpu_w returns.
- MEM_LATENCY=3, mem[0..2] non-HALT, mem[3]=16'hE000 → three loads, halted=1, pc=3, no ir_load/cpu_s for address 3.
- pc=8'hFF, non-HALT instruction completes → pc=8'h00.
- pc_redirect=1, pc_target=8'h40 held during DONE completion → next mem_addr=8'h40. Same inputs pulsed during BUSY only → pc increments.
- run dropped during BUSY → instruction completes, pc increments once, state IDLE, no further mem_rd. With FETCH_STEP_EN, two step pulses → exactly two fetches.

Source files
------------

// File: rtl/risc_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package risc_fetch_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    MEMWAIT,
    CAPTURE,
    LOAD,
    START,
    BUSY,
    DONE,
    HALT
  } fetch_state_t;

  localparam logic [2:0]  HALT_OPCODE_DEF = 3'b111;
  localparam int unsigned OPC_MSB         = 15;
  localparam int unsigned OPC_LSB         = 13;

  function automatic logic is_halt(input logic [2:0] opc, input logic [2:0] halt_opc);
    return opc == halt_opc;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: advances by one or loads a redirect target.
module pc_reg #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_advance,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_target,
  output logic [WIDTH-1:0] o_pc
);

  logic [WIDTH-1:0] r_pc;

  // PC update only on instruction completion; wraps modulo 2^WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_VAL;
    end else if (i_advance) begin
      r_pc <= i_redirect ? i_target : r_pc + WIDTH'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads instructions, hands them to the core with
// load/start strobes, and advances or redirects the PC on completion.
// Optional single-step mode: define FETCH_STEP_EN to add the `step` input.
module fetch_unit
  import risc_fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = 8,
  parameter int unsigned          INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned          MEM_LATENCY = 1,
  parameter logic [2:0]           HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
`ifdef FETCH_STEP_EN
  input  logic                   step,
`endif
  output logic [PC_WIDTH-1:0]    mem_addr,
  output logic                   mem_rd,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [INSTR_WIDTH-1:0] ir_out,
  output logic                   ir_load,
  output logic                   cpu_s,
  input  logic                   cpu_w,
  input  logic                   pc_redirect,
  input  logic [PC_WIDTH-1:0]    pc_target,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted
);

  // Last MEMWAIT count value before moving on to CAPTURE.
  localparam logic [1:0] LAT_LAST = (MEM_LATENCY > 1) ? 2'(MEM_LATENCY - 2) : 2'd0;

  fetch_state_t           r_state;
  fetch_state_t           w_next;
  logic [1:0]             r_cnt;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic                   w_advance;
  logic                   w_start_ok;
  logic                   w_continue;

`ifdef FETCH_STEP_EN
  assign w_start_ok = step & cpu_w;
  assign w_continue = 1'b0;
`else
  assign w_start_ok = run & cpu_w;
  assign w_continue = run;
`endif

  pc_reg #(
    .WIDTH     (PC_WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (reset),
    .i_advance  (w_advance),
    .i_redirect (pc_redirect),
    .i_target   (pc_target),
    .o_pc       (pc)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Shared cycle counter for MEMWAIT latency and the BUSY timeout; cleared elsewhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 r_cnt <= '0;
    else if (r_state == MEMWAIT || r_state == BUSY) r_cnt <= r_cnt + 2'd1;
    else                                        r_cnt <= '0;
  end

  // Instruction register: captured once per fetch, held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_ir <= '0;
    else if (r_state == CAPTURE) r_ir <= mem_rdata;
  end

  // Next-state and strobe decode.
  always_comb begin
    w_next    = r_state;
    mem_rd    = 1'b0;
    ir_load   = 1'b0;
    cpu_s     = 1'b0;
    w_advance = 1'b0;
    unique case (r_state)
      IDLE:    if (w_start_ok) w_next = FETCH;
      FETCH: begin
        mem_rd = 1'b1;
        w_next = (MEM_LATENCY > 1) ? MEMWAIT : CAPTURE;
      end
      MEMWAIT: if (r_cnt == LAT_LAST) w_next = CAPTURE;
      CAPTURE: w_next = is_halt(mem_rdata[OPC_MSB:OPC_LSB], HALT_OPCODE) ? HALT : LOAD;
      LOAD: begin
        ir_load = 1'b1;
        w_next  = START;
      end
      START: begin
        cpu_s  = 1'b1;
        w_next = BUSY;
      end
      // A core that finishes in one cycle never drops cpu_w; time out after two cycles.
      BUSY:    if (!cpu_w || r_cnt == 2'd1) w_next = DONE;
      DONE: begin
        if (cpu_w) begin
          w_advance = 1'b1;
          w_next    = w_continue ? FETCH : IDLE;
        end
      end
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
  end

  assign mem_addr = pc;
  assign ir_out   = r_ir;
  assign halted   = (r_state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: one instance with MEM_LATENCY=1, one with 3.
module tb_fetch_unit;

  localparam logic [15:0] POISON = 16'h1BAD;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- DUT A (latency 1) ----------------
  logic        a_run = 0, a_mem_rd, a_ir_load, a_cpu_s, a_cpu_w, a_redirect = 0, a_halted;
  logic [7:0]  a_mem_addr, a_target = 0, a_pc;
  logic [15:0] a_rdata = POISON, a_ir;
  logic [15:0] amem [256];
  int          a_busy = 0, a_bcnt = 0, a_excl = 0;
  logic [7:0]  a_ldpc[$];
  logic [15:0] a_ldir[$];
  logic [7:0]  a_fetchq[$];
`ifdef FETCH_STEP_EN
  logic        a_step = 0, b_step = 0;
`endif

  fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00), .MEM_LATENCY(1), .HALT_OPCODE(3'b111)) dut_a (
    .clk(clk), .reset(reset), .run(a_run),
`ifdef FETCH_STEP_EN
    .step(a_step),
`endif
    .mem_addr(a_mem_addr), .mem_rd(a_mem_rd), .mem_rdata(a_rdata), .ir_out(a_ir),
    .ir_load(a_ir_load), .cpu_s(a_cpu_s), .cpu_w(a_cpu_w), .pc_redirect(a_redirect),
    .pc_target(a_target), .pc(a_pc), .halted(a_halted));

  always @(posedge clk) a_rdata <= a_mem_rd ? amem[a_mem_addr] : POISON;

  always @(posedge clk or negedge reset)
    if (!reset)          a_bcnt <= 0;
    else if (a_cpu_s)    a_bcnt <= a_busy;
    else if (a_bcnt > 0) a_bcnt <= a_bcnt - 1;
  assign a_cpu_w = (a_bcnt == 0);

  always @(negedge clk) if (reset) begin
    if (a_mem_rd) a_fetchq.push_back(a_mem_addr);
    if (a_ir_load) begin a_ldpc.push_back(a_pc); a_ldir.push_back(a_ir); end
    if ($countones({a_mem_rd, a_ir_load, a_cpu_s}) > 1) a_excl++;
  end

  // ---------------- DUT B (latency 3) ----------------
  logic        b_run = 0, b_mem_rd, b_ir_load, b_cpu_s, b_cpu_w, b_halted;
  logic [7:0]  b_mem_addr, b_pc;
  logic [15:0] b_ir, b_p0 = POISON, b_p1 = POISON, b_p2 = POISON;
  logic [15:0] bmem [256];
  int          b_busy = 0, b_bcnt = 0, b_excl = 0;
  logic [7:0]  b_ldpc[$];
  logic [15:0] b_ldir[$];
  logic [7:0]  b_fetchq[$];

  fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00), .MEM_LATENCY(3), .HALT_OPCODE(3'b111)) dut_b (
    .clk(clk), .reset(reset), .run(b_run),
`ifdef FETCH_STEP_EN
    .step(b_step),
`endif
    .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_rdata(b_p2), .ir_out(b_ir),
    .ir_load(b_ir_load), .cpu_s(b_cpu_s), .cpu_w(b_cpu_w), .pc_redirect(1'b0),
    .pc_target(8'h00), .pc(b_pc), .halted(b_halted));

  always @(posedge clk) begin
    b_p0 <= b_mem_rd ? bmem[b_mem_addr] : POISON;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end

  always @(posedge clk or negedge reset)
    if (!reset)          b_bcnt <= 0;
    else if (b_cpu_s)    b_bcnt <= b_busy;
    else if (b_bcnt > 0) b_bcnt <= b_bcnt - 1;
  assign b_cpu_w = (b_bcnt == 0);

  always @(negedge clk) if (reset) begin
    if (b_mem_rd) b_fetchq.push_back(b_mem_addr);
    if (b_ir_load) begin b_ldpc.push_back(b_pc); b_ldir.push_back(b_ir); end
    if ($countones({b_mem_rd, b_ir_load, b_cpu_s}) > 1) b_excl++;
  end

  // ---------------- helpers ----------------
  task automatic fill_mems();
    for (int i = 0; i < 256; i++) begin
      amem[i] = {3'($urandom_range(0, 6)), 13'($urandom)};
      bmem[i] = {3'($urandom_range(0, 6)), 13'($urandom)};
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 0; a_run = 0; b_run = 0; a_redirect = 0; a_target = 0; a_busy = 0; b_busy = 0;
`ifdef FETCH_STEP_EN
    a_step = 0; b_step = 0;
`endif
    repeat (2) @(negedge clk);
    a_ldpc.delete(); a_ldir.delete(); a_fetchq.delete();
    b_ldpc.delete(); b_ldir.delete(); b_fetchq.delete();
    reset = 1;
  endtask

  // which: 0 a_mem_rd, 1 a_ir_load, 2 a_cpu_s, 3 b_halted
  task automatic wait_sig(input int which, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      case (which)
        0: ok = a_mem_rd;
        1: ok = a_ir_load;
        2: ok = a_cpu_s;
        default: ok = b_halted;
      endcase
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [27:0] obs;
    #1 reset = 0;
    #2;
    obs = {a_pc, a_mem_addr, a_mem_rd, a_ir_load, a_cpu_s, a_halted, 8'h00};
    n_tests++;
    if (obs !== '0 || a_ir !== 16'h0) begin
      n_fail++; $display("FAIL reset_a: got pc=%h addr=%h rd=%b ld=%b s=%b h=%b ir=%h want all 0",
                         a_pc, a_mem_addr, a_mem_rd, a_ir_load, a_cpu_s, a_halted, a_ir);
    end
    obs = {b_pc, b_mem_addr, b_mem_rd, b_ir_load, b_cpu_s, b_halted, 8'h00};
    n_tests++;
    if (obs !== '0 || b_ir !== 16'h0) begin
      n_fail++; $display("FAIL reset_b: got pc=%h addr=%h rd=%b ld=%b s=%b h=%b ir=%h want all 0",
                         b_pc, b_mem_addr, b_mem_rd, b_ir_load, b_cpu_s, b_halted, b_ir);
    end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_latency();
    int t0, rd_c = -1, ld_c = -1, s_c = -1;
    logic [15:0] ld_ir = '0;
    apply_reset(); fill_mems();
    amem[0] = 16'hD105; a_busy = 4;
    @(negedge clk); a_run = 1; t0 = cyc;
    for (int i = 0; i < 20 && s_c < 0; i++) begin
      @(negedge clk);
      if (a_mem_rd && rd_c < 0) rd_c = cyc;
      if (a_ir_load && ld_c < 0) begin ld_c = cyc; ld_ir = a_ir; end
      if (a_cpu_s && s_c < 0) s_c = cyc;
    end
    a_run = 0;
    n_tests++; if (rd_c !== t0 + 1) begin n_fail++; $display("FAIL lat_fetch: got cycle %0d want %0d", rd_c, t0 + 1); end
    n_tests++; if (ld_c - rd_c !== 2) begin n_fail++; $display("FAIL lat_load: got offset %0d want 2", ld_c - rd_c); end
    n_tests++; if (s_c - rd_c !== 3) begin n_fail++; $display("FAIL lat_start: got offset %0d want 3", s_c - rd_c); end
    n_tests++; if (ld_ir !== 16'hD105) begin n_fail++; $display("FAIL lat_ir: got %h want d105", ld_ir); end
    repeat (20) @(negedge clk);
    n_tests++; if (a_pc !== 8'h01) begin n_fail++; $display("FAIL lat_pc: got %h want 01", a_pc); end
    n_tests++; if (a_ir !== 16'hD105) begin n_fail++; $display("FAIL lat_ir_hold: got %h want d105", a_ir); end
  endtask

  task automatic test_run_drop();
    bit ok;
    apply_reset(); fill_mems(); a_busy = 3;
    @(negedge clk); a_run = 1;
    wait_sig(2, 30, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rundrop_start: got timeout want cpu_s"); end
    @(negedge clk); a_run = 0;
    repeat (25) @(negedge clk);
    n_tests++; if (a_pc !== 8'h01) begin n_fail++; $display("FAIL rundrop_pc: got %h want 01", a_pc); end
    n_tests++; if (a_fetchq.size() != 1) begin n_fail++; $display("FAIL rundrop_fetches: got %0d want 1", a_fetchq.size()); end
  endtask

  task automatic test_redirect();
    bit ok;
    apply_reset(); fill_mems(); a_busy = 2;
    a_redirect = 1; a_target = 8'h40;
    @(negedge clk); a_run = 1;
    wait_sig(0, 30, ok);
    wait_sig(0, 40, ok);
    n_tests++; if (!ok || a_mem_addr !== 8'h40) begin n_fail++; $display("FAIL redirect_addr: got %h (ok=%0d) want 40", a_mem_addr, ok); end
    a_redirect = 0; a_run = 0;
    repeat (40) @(negedge clk);
    n_tests++; if (a_pc !== 8'h41) begin n_fail++; $display("FAIL redirect_next: got %h want 41", a_pc); end
  endtask

  task automatic test_redirect_busy();
    bit ok;
    apply_reset(); fill_mems(); a_busy = 4;
    @(negedge clk); a_run = 1;
    wait_sig(2, 30, ok);
    a_redirect = 1; a_target = 8'h40;
    @(negedge clk);
    a_redirect = 0; a_target = 8'h00; a_run = 0;
    repeat (30) @(negedge clk);
    n_tests++; if (!ok || a_pc !== 8'h01) begin n_fail++; $display("FAIL redirect_busy: got %h (ok=%0d) want 01", a_pc, ok); end
  endtask

  task automatic test_wrap();
    bit ok;
    apply_reset(); fill_mems(); a_busy = 1;
    a_redirect = 1; a_target = 8'hFF;
    @(negedge clk); a_run = 1;
    wait_sig(1, 30, ok);
    wait_sig(1, 40, ok);
    a_redirect = 0; a_run = 0;
    n_tests++; if (!ok || a_pc !== 8'hFF) begin n_fail++; $display("FAIL wrap_setup: got %h (ok=%0d) want ff", a_pc, ok); end
    repeat (30) @(negedge clk);
    n_tests++; if (a_pc !== 8'h00) begin n_fail++; $display("FAIL wrap_pc: got %h want 00", a_pc); end
    n_tests++; if (a_fetchq.size() != 2) begin n_fail++; $display("FAIL wrap_fetches: got %0d want 2", a_fetchq.size()); end
  endtask

  task automatic test_halt();
    bit ok;
    int nld, nfe;
    apply_reset(); fill_mems();
    bmem[3] = 16'hE000; b_busy = 2;
    @(negedge clk); b_run = 1;
    wait_sig(3, 200, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL halt_reached: got timeout want halted=1"); end
    nld = b_ldpc.size(); nfe = b_fetchq.size();
    repeat (15) @(negedge clk);
    n_tests++; if (b_halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b want 1", b_halted); end
    n_tests++; if (b_pc !== 8'h03 || b_mem_addr !== 8'h03) begin n_fail++; $display("FAIL halt_pc: got pc=%h addr=%h want 03", b_pc, b_mem_addr); end
    n_tests++; if (b_ir !== 16'hE000) begin n_fail++; $display("FAIL halt_ir: got %h want e000", b_ir); end
    n_tests++; if (nld != 3 || b_ldpc.size() != 3) begin n_fail++; $display("FAIL halt_loads: got %0d/%0d want 3", nld, b_ldpc.size()); end
    n_tests++; if (nfe != 4 || b_fetchq.size() != 4) begin n_fail++; $display("FAIL halt_fetches: got %0d/%0d want 4", nfe, b_fetchq.size()); end
    for (int k = 0; k < 3 && k < b_ldpc.size(); k++) begin
      n_tests++;
      if (b_ldpc[k] !== 8'(k) || b_ldir[k] !== bmem[k]) begin
        n_fail++; $display("FAIL halt_load%0d: got pc=%h ir=%h want pc=%h ir=%h", k, b_ldpc[k], b_ldir[k], 8'(k), bmem[k]);
      end
    end
    b_run = 0;
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    logic [31:0] obs;
    apply_reset(); fill_mems(); a_busy = 6;
    @(negedge clk); a_run = 1;
    ok = 1;
    for (int k = 0; k < 6 && ok; k++) wait_sig(1, 60, ok);
    if (ok) wait_sig(2, 10, ok);
    @(negedge clk);
    n_tests++; if (!ok || a_pc !== 8'h05) begin n_fail++; $display("FAIL rstbusy_setup: got %h (ok=%0d) want 05", a_pc, ok); end
    #2 reset = 0; a_run = 0;
    #1;
    obs = {a_pc, a_mem_addr, a_ir};
    n_tests++;
    if (obs !== '0 || a_mem_rd !== 0 || a_ir_load !== 0 || a_cpu_s !== 0 || a_halted !== 0) begin
      n_fail++; $display("FAIL rstbusy_async: got pc=%h addr=%h ir=%h rd=%b ld=%b s=%b h=%b want all 0",
                         a_pc, a_mem_addr, a_ir, a_mem_rd, a_ir_load, a_cpu_s, a_halted);
    end
    @(negedge clk);
    a_fetchq.delete(); a_ldpc.delete(); a_ldir.delete();
    reset = 1;
    @(negedge clk); a_run = 1;
    wait_sig(0, 10, ok);
    n_tests++; if (!ok || a_mem_addr !== 8'h00) begin n_fail++; $display("FAIL rstbusy_refetch: got %h (ok=%0d) want 00", a_mem_addr, ok); end
    a_run = 0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    localparam int N = 30;
    bit          rd [N];
    logic [7:0]  tg [N];
    int          bz [N];
    logic [7:0]  exp_pc [N];
    logic [7:0]  p;
    bit          ok;
    apply_reset(); fill_mems();
    p = 8'h00;
    for (int k = 0; k < N; k++) begin
      rd[k] = ($urandom_range(0, 3) == 0);
      tg[k] = 8'($urandom);
      bz[k] = $urandom_range(0, 5);
      exp_pc[k] = p;
      p = rd[k] ? tg[k] : p + 8'd1;
    end
    a_busy = bz[0]; a_redirect = rd[0]; a_target = tg[0];
    @(negedge clk); a_run = 1;
    ok = 1;
    for (int k = 0; k < N && ok; k++) begin
      wait_sig(1, 80, ok);
      a_busy = bz[k]; a_redirect = rd[k]; a_target = tg[k];
      if (k == N - 1) a_run = 0;
    end
    a_run = 0;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rand_progress: got timeout want %0d loads", N); end
    repeat (40) @(negedge clk);
    a_redirect = 0;
    n_tests++; if (a_ldpc.size() != N) begin n_fail++; $display("FAIL rand_loads: got %0d want %0d", a_ldpc.size(), N); end
    for (int k = 0; k < N && k < a_ldpc.size(); k++) begin
      n_tests++;
      if (a_ldpc[k] !== exp_pc[k] || a_ldir[k] !== amem[exp_pc[k]]) begin
        n_fail++; $display("FAIL rand_load%0d: got pc=%h ir=%h want pc=%h ir=%h", k, a_ldpc[k], a_ldir[k], exp_pc[k], amem[exp_pc[k]]);
      end
    end
    n_tests++; if (a_pc !== p) begin n_fail++; $display("FAIL rand_final_pc: got %h want %h", a_pc, p); end
    n_tests++; if (a_fetchq.size() != N) begin n_fail++; $display("FAIL rand_fetches: got %0d want %0d", a_fetchq.size(), N); end
  endtask

  task automatic test_strobe_exclusive();
    n_tests++; if (a_excl != 0) begin n_fail++; $display("FAIL excl_a: got %0d overlaps want 0", a_excl); end
    n_tests++; if (b_excl != 0) begin n_fail++; $display("FAIL excl_b: got %0d overlaps want 0", b_excl); end
  endtask

`ifdef FETCH_STEP_EN
  task automatic test_step();
    apply_reset(); fill_mems(); a_busy = 2;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); a_step = 1;
      @(negedge clk); a_step = 0;
      repeat (30) @(negedge clk);
    end
    n_tests++; if (a_fetchq.size() != 2) begin n_fail++; $display("FAIL step_fetches: got %0d want 2", a_fetchq.size()); end
    n_tests++; if (a_pc !== 8'h02) begin n_fail++; $display("FAIL step_pc: got %h want 02", a_pc); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef FETCH_STEP_EN
    test_step();
`else
    test_latency();
    test_run_drop();
    test_redirect();
    test_redirect_busy();
    test_wrap();
    test_halt();
    test_reset_mid_busy();
    test_random();
`endif
    test_strobe_exclusive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
